// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: releases NUM_CH reset domains in index order after a
// hold period, optionally gating each stage on a ready input with a timeout fallback.
module rst_seq_ctrl #(
  parameter int                  NUM_CH         = 4,
  parameter int                  HOLD_CYCLES    = 16,
  parameter int                  GAP_CYCLES     = 8,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [NUM_CH-1:0]   READY_MASK     = {NUM_CH{1'b0}}
) (
  input  logic              clk_clk,
  input  logic              reset_in0_reset,
  input  logic [NUM_CH-1:0] sw_reset_req,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] reset_out_reset,
  output logic [NUM_CH-1:0] reset_out_reset_n,
  output logic              seq_done,
  output logic [3:0]        seq_stage,
  output logic [NUM_CH-1:0] timeout_err
);

  localparam int MAX_A   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_CH   = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {HOLD, WAIT_RDY, GAP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]        stage_reg, stage_next;
  logic [3:0]        start_reg, start_next;
  logic [NUM_CH-1:0] rst_reg, rst_next;
  logic [NUM_CH-1:0] rst_n_reg;
  logic [NUM_CH-1:0] err_reg, err_next;
  logic              expired_reg, expired_next;
  logic              done_reg, done_next;
  logic [NUM_CH-1:0] sw_prev_reg;
  logic [NUM_CH-1:0] sw_edge;

  logic              sel_mask, sel_ready, stage_met, stage_forced;
  logic [3:0]        sw_m;
  logic              sw_any, sw_apply;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_edge
    assign sw_edge[gi] = sw_reset_req[gi] & ~sw_prev_reg[gi];
  end

  // Lowest-index edge wins; scanning high-to-low lets the last hit be the lowest.
  always_comb begin
    sw_m      = 4'd0;
    sw_any    = 1'b0;
    sel_mask  = 1'b0;
    sel_ready = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sw_edge[i]) begin
        sw_m   = 4'(i);
        sw_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (stage_reg == 4'(i)) begin
        sel_mask  = READY_MASK[i];
        sel_ready = ch_ready[i];
      end
    end
  end

  // Edges on domains still held are meaningless; only released domains can be re-reset.
  assign sw_apply     = sw_any && ((state_reg == DONE) || (sw_m < stage_reg));
  // Timeout expiry is registered, so a forced release lands one cycle after the last count.
  assign stage_met    = !sel_mask || sel_ready || expired_reg;
  assign stage_forced = sel_mask && !sel_ready && expired_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stage_next   = stage_reg;
    start_next   = start_reg;
    rst_next     = rst_reg;
    err_next     = err_reg;
    expired_next = 1'b0;
    case (state_reg)
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = WAIT_RDY;
          cnt_next   = '0;
          stage_next = start_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (stage_met) begin
          cnt_next = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (stage_reg == 4'(i)) begin
              rst_next[i] = 1'b0;
              if (stage_forced) err_next[i] = 1'b1;
            end
          end
          if (stage_reg == LAST_CH) begin
            state_next = DONE;
          end else begin
            stage_next = stage_reg + 4'd1;
            state_next = (GAP_CYCLES == 0) ? WAIT_RDY : GAP;
          end
        end else begin
          cnt_next     = cnt_reg + 1'b1;
          expired_next = (cnt_reg == TO_LAST);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = WAIT_RDY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
    if (sw_apply) begin
      state_next   = HOLD;
      cnt_next     = '0;
      stage_next   = sw_m;
      start_next   = sw_m;
      expired_next = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (4'(i) >= sw_m) rst_next[i] = 1'b1;
      end
    end
    done_next = (state_reg == DONE) && !sw_apply;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_in0_reset) begin
      state_reg   <= HOLD;
      cnt_reg     <= '0;
      stage_reg   <= 4'd0;
      start_reg   <= 4'd0;
      rst_reg     <= '1;
      rst_n_reg   <= '0;
      err_reg     <= '0;
      expired_reg <= 1'b0;
      done_reg    <= 1'b0;
      sw_prev_reg <= sw_reset_req;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      stage_reg   <= stage_next;
      start_reg   <= start_next;
      rst_reg     <= rst_next;
      rst_n_reg   <= ~rst_next;
      err_reg     <= err_next;
      expired_reg <= expired_next;
      done_reg    <= done_next;
      sw_prev_reg <= sw_reset_req;
    end
  end

  assign reset_out_reset   = rst_reg;
  assign reset_out_reset_n = rst_n_reg;
  assign seq_done          = done_reg;
  assign seq_stage         = stage_reg;
  assign timeout_err       = err_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: nominal sequencing, timeout, ready gating,
// software re-reset and master reset mid-sequence, with hand-computed cycle numbers.
module tb_rst_seq_ctrl;

  logic       clk_clk = 1'b0;
  logic       reset_in0_reset = 1'b1;
  logic [3:0] sw_reset_req = 4'b0000;
  logic [3:0] ch_ready = 4'b1111;
  logic [3:0] reset_out_reset;
  logic [3:0] reset_out_reset_n;
  logic       seq_done;
  logic [3:0] seq_stage;
  logic [3:0] timeout_err;

  int rel = 0;
  int base = 0;
  int n_vec = 0;
  int n_mis = 0;

  rst_seq_ctrl #(
    .NUM_CH(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .TIMEOUT_CYCLES(32),
    .READY_MASK(4'b0110)
  ) dut (
    .clk_clk(clk_clk),
    .reset_in0_reset(reset_in0_reset),
    .sw_reset_req(sw_reset_req),
    .ch_ready(ch_ready),
    .reset_out_reset(reset_out_reset),
    .reset_out_reset_n(reset_out_reset_n),
    .seq_done(seq_done),
    .seq_stage(seq_stage),
    .timeout_err(timeout_err)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %-12s t=%0d observed=%0h expected=%0h", tag, rel, obs, expv);
    end else begin
      $display("ok   %-12s t=%0d value=%0h", tag, rel, obs);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
    rel++;
  endtask

  task automatic wait_to(input int t);
    while (rel < t) step();
  endtask

  task automatic chk_rst(input string tag, input logic [3:0] e);
    logic [3:0] en;
    en = ~e;
    chk(tag, 32'(reset_out_reset), 32'(e));
    chk({tag, "_n"}, 32'(reset_out_reset_n), 32'(en));
  endtask

  task automatic apply_reset();
    reset_in0_reset = 1'b1;
    repeat (3) step();
    chk_rst("rst_out", 4'b1111);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_stage", 32'(seq_stage), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    reset_in0_reset = 1'b0;
    rel = 0;
  endtask

  task automatic pulse_sw(input logic [3:0] v);
    sw_reset_req = v;
    step();
    sw_reset_req = 4'b0000;
  endtask

  task automatic nominal();
    wait_to(16); chk_rst("nom16", 4'b1111); chk("nom16_stg", 32'(seq_stage), 32'd0);
    wait_to(17); chk_rst("nom17", 4'b1110);
    wait_to(25); chk_rst("nom25", 4'b1110);
    wait_to(26); chk_rst("nom26", 4'b1100); chk("nom26_stg", 32'(seq_stage), 32'd2);
    wait_to(35); chk_rst("nom35", 4'b1000);
    wait_to(43); chk_rst("nom43", 4'b1000);
    wait_to(44); chk_rst("nom44", 4'b0000); chk("nom44_done", 32'(seq_done), 32'd0);
    wait_to(45); chk("nom45_done", 32'(seq_done), 32'd1); chk("nom45_stg", 32'(seq_stage), 32'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d observed=timeout expected=finish", rel);
    $fatal(1);
  end

  initial begin
    // Nominal release order with every ready present
    repeat (2) @(posedge clk_clk);
    #1;
    apply_reset();
    nominal();

    // Stage 1 never becomes ready: forced release after the timeout
    ch_ready = 4'b1101;
    apply_reset();
    wait_to(17); chk_rst("to17", 4'b1110);
    wait_to(57); chk_rst("to57", 4'b1110); chk("to57_err", 32'(timeout_err), 32'd0);
    wait_to(58); chk_rst("to58", 4'b1100); chk("to58_err", 32'(timeout_err), 32'h2);
    wait_to(67); chk_rst("to67", 4'b1000);
    wait_to(76); chk_rst("to76", 4'b0000); chk("to76_done", 32'(seq_done), 32'd0);
    wait_to(77); chk("to77_done", 32'(seq_done), 32'd1); chk("to77_err", 32'(timeout_err), 32'h2);

    // Software reset of domain 2 from DONE
    wait_to(80);
    pulse_sw(4'b0100);
    base = rel;
    chk_rst("sw2_a", 4'b1100); chk("sw2_done", 32'(seq_done), 32'd0);
    chk("sw2_stg", 32'(seq_stage), 32'd2);
    wait_to(base + 16); chk_rst("sw2_a16", 4'b1100);
    wait_to(base + 17); chk_rst("sw2_a17", 4'b1000);
    wait_to(base + 25); chk_rst("sw2_a25", 4'b1000);
    wait_to(base + 26); chk_rst("sw2_a26", 4'b0000); chk("sw2_a26_dn", 32'(seq_done), 32'd0);
    wait_to(base + 27); chk("sw2_a27_dn", 32'(seq_done), 32'd1);
    chk("sw2_err", 32'(timeout_err), 32'h2);

    // Full re-sequence, then master reset during the gap after stage 1
    ch_ready = 4'b1111;
    wait_to(rel + 3);
    pulse_sw(4'b0001);
    base = rel;
    chk_rst("sw0_a", 4'b1111); chk("sw0_stg", 32'(seq_stage), 32'd0);
    wait_to(base + 17); chk_rst("sw0_a17", 4'b1110);
    wait_to(base + 26); chk_rst("sw0_a26", 4'b1100);
    wait_to(base + 28); chk("gap_stg", 32'(seq_stage), 32'd2);
    reset_in0_reset = 1'b1;
    step();
    chk_rst("mrst", 4'b1111); chk("mrst_err", 32'(timeout_err), 32'd0);
    chk("mrst_stg", 32'(seq_stage), 32'd0); chk("mrst_done", 32'(seq_done), 32'd0);
    apply_reset();
    nominal();

    // Ready for stage 1 arrives at cycle 40
    ch_ready = 4'b1101;
    apply_reset();
    wait_to(40); chk_rst("rdy40", 4'b1110); chk("rdy40_stg", 32'(seq_stage), 32'd1);
    ch_ready = 4'b1111;
    step();
    chk_rst("rdy41", 4'b1100); chk("rdy41_err", 32'(timeout_err), 32'd0);
    wait_to(50); chk_rst("rdy50", 4'b1000);
    wait_to(59); chk_rst("rdy59", 4'b0000);
    wait_to(60); chk("rdy60_done", 32'(seq_done), 32'd1); chk("rdy60_err", 32'(timeout_err), 32'd0);

    // Software reset while stage 2 waits: lowest edge wins, held-domain edge ignored
    ch_ready = 4'b1011;
    apply_reset();
    wait_to(26); chk_rst("w26", 4'b1100);
    wait_to(40); chk("w40_stg", 32'(seq_stage), 32'd2);
    pulse_sw(4'b1001);
    chk_rst("m0_41", 4'b1111); chk("m0_stg", 32'(seq_stage), 32'd0);
    chk("m0_done", 32'(seq_done), 32'd0);
    wait_to(57); chk_rst("m0_57", 4'b1111);
    wait_to(58); chk_rst("m0_58", 4'b1110);
    wait_to(67); chk_rst("m0_67", 4'b1100);
    wait_to(80); chk("w80_stg", 32'(seq_stage), 32'd2);
    pulse_sw(4'b1000);
    chk_rst("ign81", 4'b1100); chk("ign81_stg", 32'(seq_stage), 32'd2);
    chk("ign81_err", 32'(timeout_err), 32'd0);
    wait_to(107); chk_rst("w107", 4'b1100); chk("w107_err", 32'(timeout_err), 32'd0);
    wait_to(108); chk_rst("w108", 4'b1000); chk("w108_err", 32'(timeout_err), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised multi-domain reset sequencer. It generalises the single-input, single-output reset controllers in the reset subsystem to NUM_CH output domains.
- Releases domains in fixed order 0..NUM_CH-1 after a hold period. Each stage gates on an optional per-domain ready/lock input, with a timeout.
- Supports per-domain software reset that re-asserts the requested domain and every dependent (higher-index) domain, then re-sequences them.
- Sits in rst_ss between the CSR reset and the DSP/eCPRI/Ethernet domain reset synchronisers.

Parameters:
- NUM_CH, 4, number of sequenced reset domains (1..16).
- HOLD_CYCLES, 16, cycles all pending domains stay asserted before the first release (>=1).
- GAP_CYCLES, 8, idle cycles between consecutive stage releases (>=0).
- TIMEOUT_CYCLES, 1024, maximum wait on ch_ready per stage before forced release (>=1).
- READY_MASK, {NUM_CH{1'b0}}, bit k=1 makes stage k wait for ch_ready[k]; bit k=0 ignores ch_ready[k].

Ports:
- clk_clk  in  1  single clock; all logic on its rising edge.
- reset_in0_reset  in  1  synchronous, active-high master reset.
- sw_reset_req  in  NUM_CH  per-domain software reset request; rising-edge detected internally.
- ch_ready  in  NUM_CH  per-domain ready/lock (e.g. PLL locked); already synchronous to clk_clk.
- reset_out_reset  out  NUM_CH  per-domain reset, active-high.
- reset_out_reset_n  out  NUM_CH  bitwise inverse of reset_out_reset, same cycle.
- seq_done  out  1  high while every domain is released.
- seq_stage  out  4  index of the stage currently being released or waited on.
- timeout_err  out  NUM_CH  sticky per-stage timeout flag.

Behaviour:
- All outputs are registered.
- Reset values while reset_in0_reset=1:
  - reset_out_reset all ones, reset_out_reset_n all zeros.
  - seq_done=0, seq_stage=0, timeout_err=0.
  - state=HOLD, hold/gap/timeout counters=0, start pointer=0, sw_reset_req edge-detect register loaded with current input (no spurious edge).
- FSM states: HOLD, WAIT_RDY, GAP, DONE.
- HOLD: counts HOLD_CYCLES cycles, then enters WAIT_RDY with stage k=start pointer.
- WAIT_RDY, stage k:
  - Condition met when READY_MASK[k]=0, or ch_ready[k]=1, or timeout counter reaches TIMEOUT_CYCLES-1.
  - When met, reset_out_reset[k] clears at the next edge.
  - If the release was forced by timeout (READY_MASK[k]=1 and ch_ready[k]=0), timeout_err[k] sets. Once set it clears only on master reset.
  - Timeout counter restarts at 0 on every WAIT_RDY entry.
- After the release of stage k:
  - If k=NUM_CH-1, go to DONE.
  - Otherwise go to GAP for GAP_CYCLES cycles, then WAIT_RDY with k+1. With GAP_CYCLES=0, GAP is skipped.
- Nominal timing, all ready inputs immediate, counting cycle 1 as the first cycle after reset_in0_reset falls:
  - reset_out_reset[k] falls at cycle HOLD_CYCLES+1+k*(GAP_CYCLES+1).
  - seq_done rises one cycle after the last release.
- DONE: seq_done=1 and seq_stage holds NUM_CH-1.
- Software reset, rising edge on sw_reset_req[j]:
  - Let m be the lowest index with an edge this cycle.
  - Applies only if m < current stage pointer, or the FSM is in DONE. In that case, next edge:
    - reset_out_reset[NUM_CH-1:m] set.
    - seq_done=0.
    - start pointer=m.
    - state=HOLD with the counter cleared.
  - Edges on domains not yet released (index >= current stage pointer, outside DONE) are ignored; those domains are still held.
  - Multiple simultaneous edges are resolved by the lowest index m.
  - Lower domains (< m) remain released throughout.
- A new master reset mid-sequence immediately restores all reset values at the next edge.
- A software reset during HOLD/GAP/WAIT_RDY restarts HOLD with the new start pointer.
- ch_ready deasserting after its stage has released has no effect.
- NUM_CH=1: GAP is never entered.

Test Plan:
1. NUM_CH=4, HOLD=16, GAP=8, READY_MASK=0; drop reset at cycle 0 -> reset_out_reset = 1111→1110@17→1100@26→1000@35→0000@44; seq_done=1@45; reset_out_reset_n always the inverse.
2. READY_MASK=0010, TIMEOUT=32, ch_ready[1] held 0 -> stage 1 waits from cycle 26, forced release at cycle 58; timeout_err=0010 (sticky); stages 2/3 follow at 67/76; seq_done@77.
3. Same as 2 but ch_ready[1] rises at cycle 40 -> reset_out_reset[1] falls at 41; timeout_err stays 0.
4. In DONE, pulse sw_reset_req=0100 -> next edge reset_out_reset=1100, seq_done=0; after 16 hold cycles bit 2 releases, bit 3 releases 9 cycles later, then seq_done=1; bits 0/1 stay 0 throughout.
5. In WAIT_RDY at stage 2, pulse sw_reset_req=1001 -> m=0: all outputs go to 1111 next edge, re-sequence from stage 0; repeat with sw_reset_req=1000 during stage 2 -> ignored.
6. Assert reset_in0_reset during GAP after stage 1 -> next edge outputs 1111, timeout_err cleared, seq_stage=0; release reset -> full nominal timing of test 1 recurs.
